// File: rtl/ofmap_pkg.sv
// Shared constants, packet field offsets, drain FSM states and the row-slice
// helper for the ofmap collector.
package ofmap_pkg;

    localparam int OUTPUT_WIDTH = 13;
    localparam int OFMAP_DIM    = 21;
    localparam int LOC_WIDTH    = 9;
    localparam int PKT_WIDTH    = 32;
    localparam int ROW_WIDTH    = 5;
    localparam int NUM_LOC      = OFMAP_DIM * OFMAP_DIM;

    localparam int SPIKE_BIT = OUTPUT_WIDTH;
    localparam int LOC_LSB   = OUTPUT_WIDTH + 1;
    localparam int TS_BIT    = LOC_LSB + LOC_WIDTH;

    localparam logic [ROW_WIDTH-1:0] LAST_ROW = ROW_WIDTH'(OFMAP_DIM - 1);

    typedef enum logic [1:0] {StIdle, StDrain, StDone} state_t;

    // Rows past the end of the map read back as zero.
    function automatic logic [OFMAP_DIM-1:0] row_slice(input logic [NUM_LOC-1:0] bits,
                                                      input logic [ROW_WIDTH-1:0] row);
        logic [LOC_WIDTH-1:0] base;
        base      = '0;
        row_slice = '0;
        if (int'(row) < OFMAP_DIM) begin
            base      = LOC_WIDTH'(row) * LOC_WIDTH'(OFMAP_DIM);
            row_slice = bits[base +: OFMAP_DIM];
        end
    endfunction

endpackage

// File: rtl/ofmap_bank.sv
// One timestep's bookkeeping: received/spike bitmaps, arrival counter and the
// pending-drain flag, with a single write port and a row read port.
module ofmap_bank
    import ofmap_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_we,
    input  logic [LOC_WIDTH-1:0] i_loc,
    input  logic                 i_spike,
    input  logic                 i_clr,
    input  logic [ROW_WIDTH-1:0] i_row,
    output logic                 o_rcvd,
    output logic                 o_pend,
    output logic [OFMAP_DIM-1:0] o_row
);

    logic [NUM_LOC-1:0]   r_rcvd;
    logic [NUM_LOC-1:0]   r_spike;
    logic [LOC_WIDTH-1:0] r_cnt;
    logic                 r_pend;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rcvd  <= '0;
            r_spike <= '0;
            r_cnt   <= '0;
            r_pend  <= 1'b0;
        end else begin
            if (i_we) begin
                r_rcvd[i_loc]  <= 1'b1;
                r_spike[i_loc] <= i_spike;
                r_cnt          <= r_cnt + 1'b1;
                if (r_cnt == LOC_WIDTH'(NUM_LOC - 1)) begin
                    r_pend <= 1'b1;
                end
            end
            if (i_clr) begin
                r_pend <= 1'b0;
            end
        end
    end

    assign o_rcvd = (i_loc < LOC_WIDTH'(NUM_LOC)) ? r_rcvd[i_loc] : 1'b0;
    assign o_pend = r_pend;
    assign o_row  = row_slice(r_spike, i_row);

endmodule

// File: rtl/ofmap_collector.sv
// Terminates PE result packets into two timestep banks and drains each
// completed spike map to the ofmap writer one row per beat.
module ofmap_collector
    import ofmap_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PKT_WIDTH-1:0] in_pkt,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OFMAP_DIM-1:0] out_row,
    output logic [ROW_WIDTH-1:0] out_row_idx,
    output logic                 out_timestep,
    output logic                 out_last,
    output logic                 done,
    output logic                 err_dup,
    output logic                 err_range
);

    state_t               r_state;
    logic [1:0]           r_drained;
    logic                 r_out_valid;
    logic [OFMAP_DIM-1:0] r_out_row;
    logic [ROW_WIDTH-1:0] r_out_row_idx;
    logic                 r_out_ts;
    logic                 r_out_last;
    logic                 r_done;
    logic                 r_err_dup;
    logic                 r_err_range;

    logic [LOC_WIDTH-1:0] w_loc;
    logic                 w_spike;
    logic                 w_ts;
    logic                 w_acc;
    logic                 w_in_range;
    logic                 w_hit;
    logic                 w_new;
    logic [1:0]           w_rcvd;
    logic [1:0]           w_pend;
    logic [1:0]           w_we;
    logic [1:0]           w_clr;
    logic                 w_last_acc;
    logic                 w_sel_t;
    logic [ROW_WIDTH-1:0] w_rd_row;
    logic [OFMAP_DIM-1:0] w_bank_row [2];
    logic [OFMAP_DIM-1:0] w_row_data;
    logic [1:0]           w_drained_nxt;
    logic                 w_unused_pkt;

    assign w_loc        = in_pkt[LOC_LSB +: LOC_WIDTH];
    assign w_spike      = in_pkt[SPIKE_BIT];
    assign w_ts         = in_pkt[TS_BIT];
    assign w_unused_pkt = ^{in_pkt[OUTPUT_WIDTH-1:0], in_pkt[PKT_WIDTH-1:TS_BIT+1]};

    assign in_ready   = !rst && !r_done;
    assign w_acc      = in_valid && in_ready;
    assign w_in_range = w_loc < LOC_WIDTH'(NUM_LOC);
    assign w_hit      = w_rcvd[w_ts];
    assign w_new      = w_acc && w_in_range && !w_hit;
    assign w_we[0]    = w_new && !w_ts;
    assign w_we[1]    = w_new && w_ts;

    assign w_last_acc = (r_state == StDrain) && r_out_valid && out_ready
                        && (r_out_row_idx == LAST_ROW);
    assign w_clr[0]   = w_last_acc && !r_out_ts;
    assign w_clr[1]   = w_last_acc && r_out_ts;

    // Idle preloads row 0 of the winning bank; drain prefetches the next row.
    assign w_sel_t       = (r_state == StDrain) ? r_out_ts : !w_pend[0];
    assign w_rd_row      = (r_state == StDrain) ? r_out_row_idx + 1'b1 : '0;
    assign w_row_data    = w_bank_row[w_sel_t];
    assign w_drained_nxt = r_drained | (r_out_ts ? 2'b10 : 2'b01);

    for (genvar t = 0; t < 2; t++) begin : g_bank
        ofmap_bank u_bank (
            .clk     (clk),
            .rst     (rst),
            .i_we    (w_we[t]),
            .i_loc   (w_loc),
            .i_spike (w_spike),
            .i_clr   (w_clr[t]),
            .i_row   (w_rd_row),
            .o_rcvd  (w_rcvd[t]),
            .o_pend  (w_pend[t]),
            .o_row   (w_bank_row[t])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= StIdle;
            r_drained     <= '0;
            r_out_valid   <= 1'b0;
            r_out_row     <= '0;
            r_out_row_idx <= '0;
            r_out_ts      <= 1'b0;
            r_out_last    <= 1'b0;
            r_done        <= 1'b0;
            r_err_dup     <= 1'b0;
            r_err_range   <= 1'b0;
        end else begin
            if (w_acc && w_in_range && w_hit) r_err_dup <= 1'b1;
            if (w_acc && !w_in_range)         r_err_range <= 1'b1;
            unique case (r_state)
                StIdle: begin
                    if (|w_pend) begin
                        r_state       <= StDrain;
                        r_out_valid   <= 1'b1;
                        r_out_row     <= w_row_data;
                        r_out_row_idx <= '0;
                        r_out_ts      <= w_sel_t;
                        r_out_last    <= 1'b0;
                    end
                end
                StDrain: begin
                    if (r_out_valid && out_ready) begin
                        if (r_out_row_idx == LAST_ROW) begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_drained   <= w_drained_nxt;
                            if (&w_drained_nxt) begin
                                r_state <= StDone;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= StIdle;
                            end
                        end else begin
                            r_out_row     <= w_row_data;
                            r_out_row_idx <= r_out_row_idx + 1'b1;
                            r_out_last    <= (r_out_row_idx == ROW_WIDTH'(OFMAP_DIM - 2));
                        end
                    end
                end
                StDone: ;
                default: r_state <= StIdle;
            endcase
        end
    end

    assign out_valid    = r_out_valid;
    assign out_row      = r_out_row;
    assign out_row_idx  = r_out_row_idx;
    assign out_timestep = r_out_ts;
    assign out_last     = r_out_last;
    assign done         = r_done;
    assign err_dup      = r_err_dup;
    assign err_range    = r_err_range;

endmodule

// File: tb/tb_ofmap_collector.sv
// Directed self-checking bench for ofmap_collector: reset, single drain, errors,
// reset mid-drain, backpressure with concurrent traffic, back-to-back drains.
`timescale 1ns/1ps
module tb_ofmap_collector;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pkt = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [20:0] out_row;
    logic [4:0]  out_row_idx;
    logic        out_timestep;
    logic        out_last;
    logic        done;
    logic        err_dup;
    logic        err_range;

    int n_checks = 0;
    int n_fails  = 0;
    int got, gaps, first;

    logic [20:0] b_row  [64];
    logic [4:0]  b_idx  [64];
    logic        b_ts   [64];
    logic        b_last [64];

    ofmap_collector dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pkt       (in_pkt),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_row      (out_row),
        .out_row_idx  (out_row_idx),
        .out_timestep (out_timestep),
        .out_last     (out_last),
        .done         (done),
        .err_dup      (err_dup),
        .err_range    (err_range)
    );

    always #5 clk = ~clk;

    // Expected row r when spike = (loc % m == 0).
    function automatic logic [20:0] exp_row(input int r, input int m);
        logic [20:0] e;
        for (int c = 0; c < 21; c++) e[c] = ((r * 21 + c) % m) == 0;
        return e;
    endfunction

    task automatic send(input logic t, input int loc, input logic sp);
        in_pkt   = {8'hA5, t, 9'(loc), sp, 13'h1ABC};
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_pkt   = '0;
    endtask

    task automatic send_run(input logic t, input int m, input int lo, input int hi);
        for (int l = lo; l <= hi; l++) send(t, l, (l % m) == 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Records accepted beats; checks fields hold while stalled.
    task automatic collect(input int n, input bit toggle);
        logic [20:0] p_row;
        logic [4:0]  p_idx;
        logic        p_ts, p_last;
        bit          stalled;
        stalled = 1'b0;
        got = 0; gaps = 0; first = -1;
        p_row = '0; p_idx = '0; p_ts = 1'b0; p_last = 1'b0;
        for (int cyc = 0; cyc < 400 && got < n; cyc++) begin
            out_ready = toggle ? ((cyc % 2) == 1) : 1'b1;
            if (out_valid) begin
                if (stalled) begin
                    n_checks++;
                    if (out_row !== p_row || out_row_idx !== p_idx || out_timestep !== p_ts
                        || out_last !== p_last) begin
                        n_fails++;
                        $display("FAIL stall_hold: row=%h idx=%0d ts=%b last=%b, required row=%h idx=%0d ts=%b last=%b",
                                 out_row, out_row_idx, out_timestep, out_last, p_row, p_idx, p_ts, p_last);
                    end
                end
                if (out_ready) begin
                    if (got == 0) first = cyc;
                    b_row[got] = out_row; b_idx[got] = out_row_idx;
                    b_ts[got] = out_timestep; b_last[got] = out_last;
                    got++;
                end
            end else if (got > 0) begin
                gaps++;
            end
            stalled = out_valid && !out_ready;
            p_row = out_row; p_idx = out_row_idx; p_ts = out_timestep; p_last = out_last;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        n_checks++;
        if (got != n) begin
            n_fails++;
            $display("FAIL beat_count: got %0d beats, required %0d", got, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin n_fails++; $display("FAIL rst_in_ready: %b required 0", in_ready); end
        n_checks++;
        if ({out_valid, out_row, out_row_idx, out_timestep, out_last} !== 29'd0) begin
            n_fails++;
            $display("FAIL rst_outputs: valid=%b row=%h idx=%0d ts=%b last=%b required all 0",
                     out_valid, out_row, out_row_idx, out_timestep, out_last);
        end
        n_checks++;
        if ({done, err_dup, err_range} !== 3'b000) begin
            n_fails++; $display("FAIL rst_flags: done/dup/range=%b required 000", {done, err_dup, err_range});
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fails++; $display("FAIL post_rst_in_ready: %b required 1", in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_single_drain();
        send_run(1'b0, 3, 0, 440);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fails++; $display("FAIL early_valid: %b required 0", out_valid); end
        collect(21, 1'b0);
        n_checks++;
        if (first !== 1) begin n_fails++; $display("FAIL first_beat_latency: %0d required 1", first); end
        n_checks++;
        if (b_row[0] !== 21'h049249) begin n_fails++; $display("FAIL row0_pattern: %h required 049249", b_row[0]); end
        for (int k = 0; k < 21; k++) begin
            n_checks++;
            if (b_idx[k] !== 5'(k) || b_row[k] !== exp_row(k, 3) || b_ts[k] !== 1'b0
                || b_last[k] !== (k == 20)) begin
                n_fails++;
                $display("FAIL single_beat%0d: idx=%0d row=%h ts=%b last=%b, required idx=%0d row=%h ts=0 last=%b",
                         k, b_idx[k], b_row[k], b_ts[k], b_last[k], k, exp_row(k, 3), (k == 20));
            end
        end
        n_checks++;
        if ({out_valid, done, err_dup, err_range, in_ready} !== 5'b00001) begin
            n_fails++;
            $display("FAIL after_single: valid/done/dup/range/ready=%b required 00001",
                     {out_valid, done, err_dup, err_range, in_ready});
        end
    endtask

    task automatic test_errors_and_reset();
        do_reset();
        send_run(1'b0, 3, 0, 9);
        n_checks++;
        if (err_dup !== 1'b0) begin n_fails++; $display("FAIL dup_before: %b required 0", err_dup); end
        send(1'b0, 5, 1'b1);
        n_checks++;
        if (err_dup !== 1'b1) begin n_fails++; $display("FAIL err_dup_set: %b required 1", err_dup); end
        send(1'b0, 441, 1'b1);
        n_checks++;
        if (err_range !== 1'b1) begin n_fails++; $display("FAIL err_range_set: %b required 1", err_range); end
        send_run(1'b0, 3, 10, 440);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fails++; $display("FAIL dup_counted: out_valid=%b required 0", out_valid); end
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b1 || out_row_idx !== 5'd0 || out_row !== 21'h049249) begin
            n_fails++;
            $display("FAIL err_run_row0: valid=%b idx=%0d row=%h required 1 0 049249", out_valid, out_row_idx, out_row);
        end
        repeat (10) @(posedge clk);
        #1;
        n_checks++;
        if (out_row_idx !== 5'd10 || out_row !== exp_row(10, 3)) begin
            n_fails++; $display("FAIL row10: idx=%0d row=%h required 10 %h", out_row_idx, out_row, exp_row(10, 3));
        end
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({out_valid, out_row, out_row_idx, out_timestep, out_last, done, err_dup, err_range, in_ready}
            !== 33'd0) begin
            n_fails++;
            $display("FAIL mid_drain_rst: valid=%b row=%h idx=%0d ts=%b last=%b done=%b dup=%b range=%b ready=%b required all 0",
                     out_valid, out_row, out_row_idx, out_timestep, out_last, done, err_dup, err_range, in_ready);
        end
        rst = 1'b0;
    endtask

    task automatic test_ready_toggle();
        send_run(1'b0, 5, 0, 440);
        fork
            send_run(1'b1, 2, 0, 29);
            collect(21, 1'b1);
        join
        for (int k = 0; k < 21; k++) begin
            n_checks++;
            if (b_idx[k] !== 5'(k) || b_row[k] !== exp_row(k, 5) || b_ts[k] !== 1'b0
                || b_last[k] !== (k == 20)) begin
                n_fails++;
                $display("FAIL toggle_beat%0d: idx=%0d row=%h ts=%b last=%b, required idx=%0d row=%h ts=0 last=%b",
                         k, b_idx[k], b_row[k], b_ts[k], b_last[k], k, exp_row(k, 5), (k == 20));
            end
        end
        n_checks++;
        if ({out_valid, done} !== 2'b00) begin
            n_fails++; $display("FAIL after_t0: valid/done=%b required 00", {out_valid, done});
        end
        send_run(1'b1, 2, 30, 440);
        collect(21, 1'b0);
        for (int k = 0; k < 21; k++) begin
            n_checks++;
            if (b_idx[k] !== 5'(k) || b_row[k] !== exp_row(k, 2) || b_ts[k] !== 1'b1
                || b_last[k] !== (k == 20)) begin
                n_fails++;
                $display("FAIL t1_beat%0d: idx=%0d row=%h ts=%b last=%b, required idx=%0d row=%h ts=1 last=%b",
                         k, b_idx[k], b_row[k], b_ts[k], b_last[k], k, exp_row(k, 2), (k == 20));
            end
        end
        n_checks++;
        if ({done, in_ready, err_dup, err_range} !== 4'b1000) begin
            n_fails++;
            $display("FAIL done_after_both: done/ready/dup/range=%b required 1000", {done, in_ready, err_dup, err_range});
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        send_run(1'b0, 7, 0, 439);
        send_run(1'b1, 2, 0, 439);
        send(1'b0, 440, (440 % 7) == 0);
        send(1'b1, 440, 1'b1);
        collect(42, 1'b0);
        n_checks++;
        if (gaps !== 1) begin n_fails++; $display("FAIL idle_gap: %0d cycles required 1", gaps); end
        for (int k = 0; k < 42; k++) begin
            n_checks++;
            if (b_idx[k] !== 5'(k % 21) || b_row[k] !== exp_row(k % 21, (k < 21) ? 7 : 2)
                || b_ts[k] !== (k >= 21) || b_last[k] !== ((k % 21) == 20)) begin
                n_fails++;
                $display("FAIL b2b_beat%0d: idx=%0d row=%h ts=%b last=%b, required idx=%0d row=%h ts=%b last=%b",
                         k, b_idx[k], b_row[k], b_ts[k], b_last[k], k % 21,
                         exp_row(k % 21, (k < 21) ? 7 : 2), (k >= 21), ((k % 21) == 20));
            end
        end
        n_checks++;
        if ({out_valid, done, in_ready} !== 3'b010) begin
            n_fails++; $display("FAIL b2b_done: valid/done/ready=%b required 010", {out_valid, done, in_ready});
        end
    endtask

    initial begin
        test_reset();
        test_single_drain();
        test_errors_and_reset();
        test_ready_toggle();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
